fw_instr_sequencer: RTL and testbench

//   Upstream instruction source for the linear PE array. Walks the Floyd-Warshall pass loop
//   and emits one instruction per accepted transfer onto the instruction bus. Each PE's

---
 rtl/fw_instr_sequencer_pkg.sv | 28 ++
 rtl/fw_instr_sequencer_if.sv | 22 ++
 rtl/fw_instr_pack.sv | 15 +
 rtl/fw_instr_sequencer_chk.sv | 46 ++++
 rtl/fw_instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fw_instr_sequencer.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/fw_instr_sequencer_pkg.sv
// Shared definitions for the Floyd-Warshall instruction path: opcodes, sequencer
// states and the instruction width helper used by every instruction source.
package fw_instr_sequencer_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_IDLE    = 3'd0,
    OP_READ0   = 3'd1,
    OP_READ1   = 3'd2,
    OP_COMPUTE = 3'd3,
    OP_FORWARD = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Instruction layout is {fwd, id[log_b-1:0], op[OP_WIDTH-1:0]}.
  function automatic int instr_width(input int log_b);
    return 1 + log_b + OP_WIDTH;
  endfunction

endpackage

// File: rtl/fw_instr_sequencer_if.sv
// Valid/ready instruction bus between an instruction source and the PE array decoders.
interface fw_instr_sequencer_if #(
  parameter int INSTR_WIDTH = 7
);

  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fw_instr_pack.sv
// Packs the instruction fields into the bus word; shared by every instruction source.
module fw_instr_pack
  import fw_instr_sequencer_pkg::*;
#(
  parameter int logB = 3
) (
  input  logic                          fwd,
  input  logic [logB-1:0]               id,
  input  op_e                           op,
  output logic [instr_width(logB)-1:0]  instr
);

  assign instr = {fwd, id, op};

endmodule

// File: rtl/fw_instr_sequencer_chk.sv
// Protocol checker for the instruction bus: hold-while-stalled, idle encoding, done/busy exclusion.
module fw_instr_sequencer_chk #(
  parameter int W = 7
) (
  input logic         clk,
  input logic         rst,
  input logic [W-1:0] instr_out,
  input logic         instr_valid,
  input logic         instr_ready,
  input logic         busy,
  input logic         done
);

  logic         stall_r;
  logic [W-1:0] prev_instr_r;

  // Remember whether the previous cycle was a stall and what was on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r      <= 1'b0;
      prev_instr_r <= '0;
    end else begin
      stall_r      <= instr_valid && !instr_ready;
      prev_instr_r <= instr_out;
    end
  end

  // Bus rules checked on every active edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      if (stall_r) begin
        a_hold: assert (instr_valid && (instr_out == prev_instr_r))
          else $error("chk: instruction changed or dropped while stalled");
      end
      if (!instr_valid) begin
        a_idle: assert (instr_out == '0)
          else $error("chk: non-idle instruction with valid low");
      end
      if (done) begin
        a_done: assert (!busy && !instr_valid)
          else $error("chk: done overlaps busy or valid");
      end
    end
  end

endmodule

// File: rtl/fw_instr_sequencer.sv
// Floyd-Warshall pass sequencer: per pass issues READ0 and READ1 to every PE, then N COMPUTEs,
// through a registered valid/ready bus that stalls on backpressure.
module fw_instr_sequencer
  import fw_instr_sequencer_pkg::*;
#(
  parameter int B    = 8,
  parameter int logB = 3,
  parameter int N    = 64,
  parameter int logN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fw_instr_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [logN-1:0]       pass_idx
);

  localparam int INSTR_WIDTH = instr_width(logB);
  localparam logic [logB-1:0] ID_LAST   = logB'(B - 1);
  localparam logic [logN-1:0] ROW_LAST  = logN'(N - 1);
  localparam logic [logN-1:0] PASS_LAST = logN'(N - 1);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [logB-1:0]        id_cnt_r;
  logic [logB-1:0]        id_cnt_nxt_s;
  logic [logN-1:0]        row_cnt_r;
  logic [logN-1:0]        row_cnt_nxt_s;
  logic [logN-1:0]        pass_idx_r;
  logic [logN-1:0]        pass_idx_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic                   instr_valid_r;
  logic                   valid_nxt_s;
  logic [INSTR_WIDTH-1:0] instr_out_r;
  logic [INSTR_WIDTH-1:0] instr_nxt_s;
  logic                   fwd_nxt_s;
  logic [logB-1:0]        id_field_s;
  op_e                    op_nxt_s;
  logic                   xfer_s;

  assign xfer_s = instr_valid_r && bus.instr_ready;

  // Next-state and counter update; counters only move on a transfer.
  always_comb begin
    state_nxt_s    = state_r;
    id_cnt_nxt_s   = id_cnt_r;
    row_cnt_nxt_s  = row_cnt_r;
    pass_idx_nxt_s = pass_idx_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s    = S_RD0;
          id_cnt_nxt_s   = '0;
          row_cnt_nxt_s  = '0;
          pass_idx_nxt_s = '0;
          busy_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD0, S_RD1: begin
        if (xfer_s) begin
          if (id_cnt_r == ID_LAST) begin
            id_cnt_nxt_s = '0;
            if (state_r == S_RD0) begin
              state_nxt_s = S_RD1;
            end else begin
              state_nxt_s   = S_CMP;
              row_cnt_nxt_s = '0;
            end
          end else begin
            id_cnt_nxt_s = id_cnt_r + {{(logB-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_CMP: begin
        if (xfer_s) begin
          if (row_cnt_r == ROW_LAST) begin
            row_cnt_nxt_s = '0;
            if (pass_idx_r == PASS_LAST) begin
              state_nxt_s = S_DONE;
              busy_nxt_s  = 1'b0;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s    = S_RD0;
              pass_idx_nxt_s = pass_idx_r + {{(logN-1){1'b0}}, 1'b1};
            end
          end else begin
            row_cnt_nxt_s = row_cnt_r + {{(logN-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = S_CMP;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Instruction for the next cycle, derived from the next state so the bus stays registered.
  always_comb begin
    valid_nxt_s = 1'b0;
    op_nxt_s    = OP_IDLE;
    id_field_s  = '0;
    fwd_nxt_s   = 1'b0;
    case (state_nxt_s)
      S_RD0: begin
        valid_nxt_s = 1'b1;
        op_nxt_s    = OP_READ0;
        id_field_s  = id_cnt_nxt_s;
      end
      S_RD1: begin
        valid_nxt_s = 1'b1;
        op_nxt_s    = OP_READ1;
        id_field_s  = id_cnt_nxt_s;
      end
      S_CMP: begin
        valid_nxt_s = 1'b1;
        op_nxt_s    = OP_COMPUTE;
        id_field_s  = ID_LAST;
        fwd_nxt_s   = (pass_idx_nxt_s == PASS_LAST);
      end
      default: begin
        valid_nxt_s = 1'b0;
        op_nxt_s    = OP_IDLE;
      end
    endcase
  end

  fw_instr_pack #(
    .logB (logB)
  ) u_pack (
    .fwd   (fwd_nxt_s),
    .id    (id_field_s),
    .op    (op_nxt_s),
    .instr (instr_nxt_s)
  );

  // State, counters and all outputs register together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      id_cnt_r      <= '0;
      row_cnt_r     <= '0;
      pass_idx_r    <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_out_r   <= '0;
    end else begin
      state_r       <= state_nxt_s;
      id_cnt_r      <= id_cnt_nxt_s;
      row_cnt_r     <= row_cnt_nxt_s;
      pass_idx_r    <= pass_idx_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
      instr_valid_r <= valid_nxt_s;
      instr_out_r   <= instr_nxt_s;
    end
  end

  assign bus.instr_out   = instr_out_r;
  assign bus.instr_valid = instr_valid_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass_idx        = pass_idx_r;

endmodule

// File: tb/tb_fw_instr_sequencer.sv
// Directed bench for fw_instr_sequencer with B=4, N=4 (48 transfers per run).
module tb_fw_instr_sequencer;

  localparam int B    = 4;
  localparam int LOGB = 2;
  localparam int N    = 4;
  localparam int LOGN = 2;
  localparam int W    = 6;
  localparam int RUN  = 48;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [LOGN-1:0] pass_idx;

  int vectors;
  int miscompares;

  fw_instr_sequencer_if #(.INSTR_WIDTH(W)) bus ();

  fw_instr_sequencer #(
    .B    (B),
    .logB (LOGB),
    .N    (N),
    .logN (LOGN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .pass_idx (pass_idx)
  );

  fw_instr_sequencer_chk #(.W(W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .instr_out   (bus.instr_out),
    .instr_valid (bus.instr_valid),
    .instr_ready (bus.instr_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected n-th transfer: {fwd, id, op}; READ0=1, READ1=2, COMPUTE=3.
  function automatic logic [W-1:0] exp_instr(input int n);
    int p;
    int j;
    logic [LOGB-1:0] id;
    p = n / 12;
    j = n % 12;
    if (j < 4) begin
      id = LOGB'(j);
      return {1'b0, id, 3'd1};
    end else if (j < 8) begin
      id = LOGB'(j - 4);
      return {1'b0, id, 3'd2};
    end else begin
      return {(p == 3), 2'd3, 3'd3};
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(bus.instr_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass_idx), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 1 = random ready; start_at pulses start mid-run; stall_at holds ready low 10 cycles;
  // abort_at returns before that transfer so the caller can reset.
  task automatic run_seq(input int mode, input int start_at, input int stall_at, input int abort_at);
    int n;
    int cyc;
    int stall_left;
    bit stalled_once;
    n = 0;
    cyc = 0;
    stall_left = 0;
    stalled_once = 1'b0;
    while (n < RUN && cyc < 2000) begin
      if (n == abort_at) return;
      bus.instr_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (n == stall_at && !stalled_once) begin
        stall_left = 10;
        stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
        bus.instr_ready = 1'b0;
        stall_left--;
      end
      start = (n == start_at);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done_early", 32'(done), 32'd0);
      check("run_valid", 32'(bus.instr_valid), 32'd1);
      check($sformatf("instr_%0d", n), 32'(bus.instr_out), 32'(exp_instr(n)));
      check("pass_idx", 32'(pass_idx), 32'(n / 12));
      if (bus.instr_ready) n++;
      tick();
      cyc++;
    end
    start = 1'b0;
    bus.instr_ready = 1'b1;
    check("transfer_count", 32'(n), 32'(RUN));
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_valid", 32'(bus.instr_valid), 32'd0);
    check("done_instr", 32'(bus.instr_out), 32'd0);
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    check_idle("rst_with_start");
    rst = 1'b0;
    start = 1'b0;
    tick();
    check_idle("idle_no_start");

    // Free flow, including the fwd bit on the last pass.
    do_start();
    run_seq(0, -1, -1, -1);

    // Random backpressure.
    tick();
    do_start();
    run_seq(1, -1, -1, -1);

    // Stall at READ0 id=3 for 10 cycles.
    do_start();
    run_seq(0, -1, 3, -1);

    // Start pulsed mid-run is ignored.
    do_start();
    run_seq(0, 20, -1, -1);

    // Async reset during pass 2.
    do_start();
    run_seq(0, -1, -1, 27);
    check("pre_abort_pass", 32'(pass_idx), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_abort");
    end

    // Fresh run after abort starts from pass 0.
    do_start();
    run_seq(1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
